seq_mul_ctrl: RTL and testbench
===============================

# seq_mul_ctrl

Sequential shift-and-add multiplier controller for the lab05 multiply datapath. Accepts an operand pair on a start pulse, walks the multiplier bits one per cycle, adds `a << i` into an accumulator for each set bit `b[i]`, and presents the registered product plus a divisible-by-4 flag with a one-cycle done pulse. Sits between a requester, such as a testbench or top-level FSM, and the combinational power-of-two shift unit, which it drives with a per-cycle shift amount.

## Interface
- `N`, default 4: operand width; the product is 2N bits.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request; sampled only in IDLE.
- `a`  in  N: multiplicand; captured when start is accepted.
- `b`  in  N: multiplier; captured when start is accepted.
- `busy`  out  1: high in RUN and DONE.
- `done`  out  1: single-cycle pulse; product valid.
- `product`  out  2N: registered `a*b`; held until the next DONE.
- `be4`  out  1: registered; 1 iff `product[1:0] == 0`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `start=1` latches `a` (zero-extended to 2N) and `b`.
  - Clears the accumulator and sets bit index `i=0`.
  - Next state is RUN.
  - `start=0` stays in IDLE.
- RUN, one bit per cycle:
  - If `b_q[i]` is set, `acc <= acc + (a_q << i)`; the shift comes from the shift sub-module.
  - The sum is 2N bits wide and cannot overflow, since the maximum is (2^N-1)^2.
  - `i` increments each cycle.
  - After processing `i = N-1`: `product <= final acc`, `be4 <= (final acc[1:0]==0)`, next state is DONE.
- DONE:
  - `done=1` for exactly one cycle.
  - Next state is IDLE unconditionally.
- `start` in RUN or DONE is ignored and not queued. The captured operands are unaffected by input changes after acceptance.
- `product` and `be4` change only on entry to DONE. They are stable at all other times, including during a subsequent RUN.
- Boundaries:
  - `a=0` or `b=0` gives `product=0`, `be4=1`.
  - `a=b=2^N-1` gives `(2^N-1)^2`.
  - A start arriving in the same cycle DONE exits is ignored; the requester must reassert it in IDLE.
- Reset at any time, including mid-RUN, forces IDLE and discards the operation in flight. Reset values:
  - `busy=0`, `done=0`, `product=0`, `be4=1` (product 0 is divisible by 4).
  - Accumulator 0, `i=0`.

## Timing
- Cycle 0 is the edge at which `start` is sampled in IDLE.
- RUN occupies edges 1..N.
- `done=1` and the new `product`/`be4` are visible after edge N, and sampled at edge N+1. With N=4, done is seen at edge 5.
- DONE → IDLE at edge N+1. The earliest next accepted start is edge N+2.
- `busy` rises after edge 0 and falls after edge N+1.
- The block is fully registered: no combinational path from inputs to outputs.

## Configuration
- `SEQ_MUL_EARLY_EXIT_EN` defined:
  - In RUN, after processing bit `i`, if `b_q[N-1:i+1]` is all zero (or `i = N-1`), the block latches the product and goes to DONE.
  - Latency becomes (index of the highest set bit of b, or 0 if b=0) + 1 RUN cycles.
  - Example: `b=4'b0001` gives done seen at edge 2.
- Not defined: the fixed N RUN cycles described above.
- Results are identical either way; only latency differs.

## Structure
- Package `seq_mul_pkg`:
  - State enum type (IDLE/RUN/DONE).
  - Default width constant `MUL_N = 4`.
  - Index width `$clog2(N)`.
- One sub-module, `mul_shift_unit`:
  - Combinational; `a` (N) and shift amount `i` in, `a << i` (2N) out.
  - Generalises the fixed ×2/×4/×8 shift outputs already used in lab05.
- The controller owns the FSM, counter, accumulator and output registers.

## Test plan
- Reset, then idle: `busy=0`, `done=0`, `product=0`, `be4=1`. Hold reset mid-RUN (`a=7`, `b=9`): returns to IDLE, no done pulse, product still 0.
- `a=3`, `b=5`: done seen exactly at edge 5, `product=15`, `be4=0`, done high for one cycle, busy low after edge 6.
- `a=15`, `b=15`: `product=225`, `be4=0`. Then `a=12`, `b=3`: `product=36`, `be4=1`. Previous product is held until the second done.
- `a=0`, `b=13` and `a=9`, `b=0`: `product=0`, `be4=1`, in both macro configurations.
- Start pulses at edges 1..5 while busy, with different operands: ignored. Result is that of the first operands only, and exactly one done pulse.
- With `SEQ_MUL_EARLY_EXIT_EN`:
  - `a=6`, `b=1`: done seen at edge 2, `product=6`, `be4=0`.
  - `a=6`, `b=8`: done at edge 5, `product=48`.

Source files
------------

// File: rtl/seq_mul_pkg.sv
// Shared types and constants for the lab05 sequential shift-and-add multiplier.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MUL_N = 4;

  // Bit-index width; a 1-bit operand still needs a 1-bit counter.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_shift_unit.sv
// Combinational power-of-two shifter: zero-extends a to 2N bits and shifts left by i.
module mul_shift_unit
  import seq_mul_pkg::*;
#(
  parameter int N  = MUL_N,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]   a,
  input  logic [IW-1:0]  i,
  output logic [2*N-1:0] shifted
);

  assign shifted = {{N{1'b0}}, a} << i;

endmodule

// File: rtl/seq_mul_ctrl.sv
// Sequential shift-and-add multiplier controller, one multiplier bit per cycle.
// Define SEQ_MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module seq_mul_ctrl
  import seq_mul_pkg::*;
#(
  parameter int N = MUL_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic           be4
);

  localparam int IW = idx_w(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t           state;
  state_t           state_next;
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic [IW-1:0]    idx;
  logic [2*N-1:0]   acc;
  logic [2*N-1:0]   shifted;
  logic [2*N-1:0]   acc_next;
  logic             last_bit;
  logic             accept;

  mul_shift_unit #(
    .N  (N),
    .IW (IW)
  ) u_shift (
    .a       (a_q),
    .i       (idx),
    .shifted (shifted)
  );

  // Sum cannot exceed (2^N-1)^2, so 2N bits never overflow.
  assign acc_next = b_q[idx] ? (acc + shifted) : acc;

`ifdef SEQ_MUL_EARLY_EXIT_EN
  logic [N-1:0] b_rest;
  assign b_rest   = (b_q >> idx) >> 1;
  assign last_bit = (idx == LAST_IDX) || (b_rest == '0);
`else
  assign last_bit = (idx == LAST_IDX);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, accumulation and result registers; product/be4 move only on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      idx     <= '0;
      acc     <= '0;
      product <= '0;
      be4     <= 1'b1;
    end else if (accept) begin
      a_q <= a;
      b_q <= b;
      idx <= '0;
      acc <= '0;
    end else if (state == RUN) begin
      acc <= acc_next;
      idx <= idx + 1'b1;
      if (last_bit) begin
        product <= acc_next;
        be4     <= (acc_next[1:0] == 2'b00);
      end
    end
  end

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Scoreboard bench for seq_mul_ctrl: directed operands with hand-computed products.
module tb_seq_mul_ctrl;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;
  logic           be4;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [2*N-1:0] p;
    logic           be4;
    int             due;
  } exp_t;

  exp_t sb[$];

  seq_mul_ctrl #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .be4     (be4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Number of RUN cycles for a given multiplier.
  function automatic int run_len(input logic [N-1:0] bv);
`ifdef SEQ_MUL_EARLY_EXIT_EN
    int hb;
    hb = 0;
    for (int k = 0; k < N; k++) if (bv[k]) hb = k;
    return hb + 1;
`else
    return N;
`endif
  endfunction

  // Monitor: every done pulse must match the oldest expected result, on its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got product %0d with no request outstanding at cycle %0d", product, cyc);
      end else begin
        e = sb.pop_front();
        check("product", 32'(product), 32'(e.p));
        check("be4", 32'(be4), 32'(e.be4));
        check("done_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout got busy %0b expected 0", busy);
    end
  endtask

  // Called at a negedge; the next posedge accepts the request.
  task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv,
                       input logic [2*N-1:0] pv, input logic bev);
    exp_t e;
    wait_idle();
    a     = av;
    b     = bv;
    start = 1'b1;
    e.p   = pv;
    e.be4 = bev;
    e.due = cyc + 1 + run_len(bv);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int k;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_product", 32'(product), 0);
    check("rst_be4", 32'(be4), 1);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);

    // Reset mid-RUN: no done pulse, product untouched.
    a = 4'd7; b = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("midrun_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrun_rst_busy", 32'(busy), 0);
    check("midrun_rst_product", 32'(product), 0);
    check("midrun_rst_be4", 32'(be4), 1);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("midrun_after_product", 32'(product), 0);

    issue(4'd3, 4'd5, 8'd15, 1'b0);
    issue(4'd15, 4'd15, 8'd225, 1'b0);
    issue(4'd12, 4'd3, 8'd36, 1'b1);
    check("held_product", 32'(product), 225);
    check("held_be4", 32'(be4), 0);
    issue(4'd0, 4'd13, 8'd0, 1'b1);
    issue(4'd9, 4'd0, 8'd0, 1'b1);
    issue(4'd6, 4'd1, 8'd6, 1'b0);
    issue(4'd6, 4'd8, 8'd48, 1'b1);

    // Start pulses with new operands while busy must be ignored.
    issue(4'd3, 4'd5, 8'd15, 1'b0);
    for (int p = 0; p <= run_len(4'd5); p++) begin
      a     = 4'd15;
      b     = 4'd15;
      start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("ignored_start_idle", 32'(busy), 0);

    k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("drain", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
